pc_sequencer: RTL and testbench

- Owns the 17-bit program counter and sequences the PC-source select mux.
- Each cycle it computes the 4-bit Selection code, supplies the sequential and return operands, and registers the mux result into PC.
- Adds interrupt entry, trap entry, exception return (EPC) and a double-fault halt.
- Sits between fetch and the PC-source mux in the single-cycle CPU.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_seq_fsm.sv | 70 +++++++
 rtl/pc_sequencer.sv | 75 +++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control constants for the PC sequencer and PC-source mux.
//   PC_WIDTH    - width of PC, EPC and every mux operand
//   IRQ_VECTOR  - interrupt handler address (mux select 4 constant)
//   TRAP_VECTOR - trap handler address (mux select 5 constant)
//   SEL_*       - PC-source mux select codes
//   state_t     - sequencer state encoding
package cpu_ctrl_pkg;
   localparam int PC_WIDTH    = 17;
   localparam int IRQ_VECTOR  = 22;
   localparam int TRAP_VECTOR = 12;
   localparam logic [3:0] SEL_SEQ    = 4'd0;
   localparam logic [3:0] SEL_BRANCH = 4'd1;
   localparam logic [3:0] SEL_JUMP   = 4'd2;
   localparam logic [3:0] SEL_REG    = 4'd3;
   localparam logic [3:0] SEL_IRQ    = 4'd4;
   localparam logic [3:0] SEL_TRAP   = 4'd5;
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_IRQ  = 2'd1,
      ST_TRAP = 2'd2,
      ST_HALT = 2'd3
   } state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and PC bus between the datapath and the PC sequencer.
//   Datapath -> sequencer: Stall, BranchTaken, Jump, JumpReg, Eret, Trap, IrqReq,
//                          RegTarget, MuxOut
//   Sequencer -> datapath: Selection, PC, SeqPC, Input4Drive, EPC, IrqAck,
//                          InHandler, Halted
//   modport master: datapath side; modport slave: sequencer side.
interface pc_sequencer_if;
   import cpu_ctrl_pkg::*;
   logic                Stall;
   logic                BranchTaken;
   logic                Jump;
   logic                JumpReg;
   logic                Eret;
   logic                Trap;
   logic                IrqReq;
   logic [PC_WIDTH-1:0] RegTarget;
   logic [PC_WIDTH-1:0] MuxOut;
   logic [3:0]          Selection;
   logic [PC_WIDTH-1:0] PC;
   logic [PC_WIDTH-1:0] SeqPC;
   logic [PC_WIDTH-1:0] Input4Drive;
   logic [PC_WIDTH-1:0] EPC;
   logic                IrqAck;
   logic                InHandler;
   logic                Halted;
   modport master (
      output Stall, BranchTaken, Jump, JumpReg, Eret, Trap, IrqReq, RegTarget, MuxOut,
      input  Selection, PC, SeqPC, Input4Drive, EPC, IrqAck, InHandler, Halted
   );
   modport slave (
      input  Stall, BranchTaken, Jump, JumpReg, Eret, Trap, IrqReq, RegTarget, MuxOut,
      output Selection, PC, SeqPC, Input4Drive, EPC, IrqAck, InHandler, Halted
   );
endinterface

// File: rtl/pc_seq_fsm.sv
// pc_seq_fsm: sequencer state register plus the prioritised PC-source select.
//   clk, rst          - clock, synchronous active-high reset
//   stall             - hold state this cycle
//   branch_taken, jump, jump_reg, eret, trap, irq_req - instruction events
//   selection         - mux select code (combinational)
//   state             - current state
//   irq_take          - interrupt accepted this cycle (unqualified by stall)
//   eret_take         - exception return accepted this cycle
//   trap_save         - trap taken from RUN: EPC captures the faulting PC
//   pc_load           - PC may load the mux result (not halted, not a double fault)
module pc_seq_fsm
   import cpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic       jump,
   input  logic       jump_reg,
   input  logic       eret,
   input  logic       trap,
   input  logic       irq_req,
   output logic [3:0] selection,
   output state_t     state,
   output logic       irq_take,
   output logic       eret_take,
   output logic       trap_save,
   output logic       pc_load
);
   state_t state_next;
   logic   in_handler;
   logic   irq_ok;
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_RUN;
      else if (!stall)
         state <= state_next;
   end
   assign in_handler = (state == ST_IRQ) || (state == ST_TRAP);
   // Any control transfer in flight defers the interrupt; Eret counts even in RUN.
   assign irq_ok = irq_req && (state == ST_RUN) && !(branch_taken || jump || jump_reg || eret);
   always_comb begin
      state_next = state;
      selection  = SEL_SEQ;
      irq_take   = 1'b0;
      eret_take  = 1'b0;
      trap_save  = 1'b0;
      pc_load    = state != ST_HALT;
      if (state != ST_HALT) begin
         if (trap) begin
            selection  = SEL_TRAP;
            state_next = in_handler ? ST_HALT : ST_TRAP;
            trap_save  = !in_handler;
            pc_load    = !in_handler;
         end else if (irq_ok) begin
            selection  = SEL_IRQ;
            state_next = ST_IRQ;
            irq_take   = 1'b1;
         end else if (eret && in_handler) begin
            selection  = SEL_REG;
            state_next = ST_RUN;
            eret_take  = 1'b1;
         end else begin
            selection = jump_reg     ? SEL_REG    :
                        jump         ? SEL_JUMP   :
                        branch_taken ? SEL_BRANCH : SEL_SEQ;
         end
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, EPC and interrupt acknowledge around pc_seq_fsm.
//   Clk, Reset - clock, synchronous active-high reset
//   bus        - pc_sequencer_if.slave: events and MuxOut in; Selection, PC,
//                SeqPC, Input4Drive, EPC, IrqAck, InHandler, Halted out
//   The PC-source mux lives outside; its select 4/5 constants must equal
//   IRQ_VECTOR/TRAP_VECTOR.
module pc_sequencer #(
   parameter int                  PC_WIDTH    = cpu_ctrl_pkg::PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int                  IRQ_VECTOR  = cpu_ctrl_pkg::IRQ_VECTOR,
   parameter int                  TRAP_VECTOR = cpu_ctrl_pkg::TRAP_VECTOR
) (
   input  logic          Clk,
   input  logic          Reset,
   pc_sequencer_if.slave bus
);
   import cpu_ctrl_pkg::*;
   // The interface and external mux are built from the package values.
   if (PC_WIDTH != cpu_ctrl_pkg::PC_WIDTH || IRQ_VECTOR != cpu_ctrl_pkg::IRQ_VECTOR ||
       TRAP_VECTOR != cpu_ctrl_pkg::TRAP_VECTOR) begin : g_cfg_check
      $error("pc_sequencer parameters disagree with cpu_ctrl_pkg");
   end
   state_t              state;
   logic                irq_take;
   logic                eret_take;
   logic                trap_save;
   logic                pc_load;
   logic                irq_ack;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] epc;
   logic [PC_WIDTH-1:0] seq_pc;
   pc_seq_fsm u_fsm (
      .clk          (Clk),
      .rst          (Reset),
      .stall        (bus.Stall),
      .branch_taken (bus.BranchTaken),
      .jump         (bus.Jump),
      .jump_reg     (bus.JumpReg),
      .eret         (bus.Eret),
      .trap         (bus.Trap),
      .irq_req      (bus.IrqReq),
      .selection    (bus.Selection),
      .state        (state),
      .irq_take     (irq_take),
      .eret_take    (eret_take),
      .trap_save    (trap_save),
      .pc_load      (pc_load)
   );
   assign seq_pc = pc + PC_WIDTH'(1);
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc      <= RESET_PC;
         epc     <= '0;
         irq_ack <= 1'b0;
      end else begin
         // Pulse only: irq_take is never set two accepted cycles running.
         irq_ack <= irq_take && !bus.Stall;
         if (!bus.Stall) begin
            if (pc_load)
               pc <= bus.MuxOut;
            if (trap_save)
               epc <= pc;
            else if (irq_take)
               epc <= seq_pc;
         end
      end
   end
   assign bus.PC          = pc;
   assign bus.SeqPC       = seq_pc;
   assign bus.EPC         = epc;
   assign bus.Input4Drive = eret_take ? epc : bus.RegTarget;
   assign bus.IrqAck      = irq_ack;
   assign bus.InHandler   = (state == ST_IRQ) || (state == ST_TRAP);
   assign bus.Halted      = state == ST_HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// behavioural model of PC, EPC, mode and acknowledge.
module tb_pc_sequencer;
   import cpu_ctrl_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] br_tgt = '0;
   logic [16:0] jmp_tgt = '0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          chk_on = 1'b0;
   logic [16:0] m_pc, m_epc;
   int          m_mode;   // 0 run, 1 irq handler, 2 trap handler, 3 halted
   bit          m_ack;
   pc_sequencer_if bus();
   pc_sequencer dut (.Clk(clk), .Reset(rst), .bus(bus));
   always #5 clk = ~clk;
   // External PC-source mux as the CPU would wire it.
   always_comb
      bus.MuxOut = bus.Selection == 4'd1 ? br_tgt :
                   bus.Selection == 4'd2 ? jmp_tgt :
                   bus.Selection == 4'd3 ? bus.Input4Drive :
                   bus.Selection == 4'd4 ? 17'(IRQ_VECTOR) :
                   bus.Selection == 4'd5 ? 17'(TRAP_VECTOR) : bus.SeqPC;
   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic clr();
      bus.Stall = 0; bus.BranchTaken = 0; bus.Jump = 0; bus.JumpReg = 0;
      bus.Eret = 0; bus.Trap = 0; bus.IrqReq = 0; bus.RegTarget = '0;
   endtask
   // Compare the DUT with the model for the current inputs, advance one clock.
   task automatic tick();
      logic [3:0]  es;
      logic [16:0] ei4, nxt;
      bit          hlt, hdl, irq, er;
      hlt = m_mode == 3;
      hdl = m_mode == 1 || m_mode == 2;
      irq = !hlt && !bus.Trap && bus.IrqReq && m_mode == 0 &&
            !(bus.BranchTaken || bus.Jump || bus.JumpReg || bus.Eret);
      er  = !hlt && !bus.Trap && !irq && bus.Eret && hdl;
      es  = hlt ? 4'd0 : bus.Trap ? 4'd5 : irq ? 4'd4 : er ? 4'd3 :
            bus.JumpReg ? 4'd3 : bus.Jump ? 4'd2 : bus.BranchTaken ? 4'd1 : 4'd0;
      ei4 = er ? m_epc : bus.RegTarget;
      if (chk_on) begin
         chk("sel", 17'(bus.Selection), 17'(es));
         chk("seqpc", bus.SeqPC, m_pc + 17'd1);
         chk("in4", bus.Input4Drive, ei4);
         chk("pc", bus.PC, m_pc);
         chk("epc", bus.EPC, m_epc);
         chk("ack", 17'(bus.IrqAck), 17'(m_ack));
         chk("inh", 17'(bus.InHandler), 17'(hdl));
         chk("halt", 17'(bus.Halted), 17'(hlt));
      end
      nxt = es == 4'd1 ? br_tgt : es == 4'd2 ? jmp_tgt : es == 4'd3 ? ei4 :
            es == 4'd4 ? 17'd22 : es == 4'd5 ? 17'd12 : m_pc + 17'd1;
      m_ack = 0;
      if (rst) begin
         m_pc = '0; m_epc = '0; m_mode = 0;
      end else if (!bus.Stall && !hlt) begin
         if (bus.Trap && hdl)
            m_mode = 3;
         else if (bus.Trap) begin
            m_epc = m_pc; m_mode = 2; m_pc = nxt;
         end else if (irq) begin
            m_epc = m_pc + 17'd1; m_mode = 1; m_ack = 1; m_pc = nxt;
         end else begin
            m_pc = nxt;
            if (er) m_mode = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      clr();
      m_pc = '0; m_epc = '0; m_mode = 0; m_ack = 0;
      rst = 1; #1; tick(); rst = 0; chk_on = 1;
      #1;
      chk("rst_pc", bus.PC, 17'd0);
      chk("rst_epc", bus.EPC, 17'd0);
      chk("rst_ack", 17'(bus.IrqAck), 17'd0);
      chk("rst_sel", 17'(bus.Selection), 17'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("idle_pc3", bus.PC, 17'd3);
      // jump and jump-register
      jmp_tgt = 17'h10; bus.Jump = 1; #1; tick();
      jmp_tgt = 17'h40; #1;
      chk("jmp_sel", 17'(bus.Selection), 17'd2);
      tick();
      chk("jmp_pc", bus.PC, 17'h40);
      clr(); bus.JumpReg = 1; bus.RegTarget = 17'h100; #1;
      chk("jr_sel", 17'(bus.Selection), 17'd3);
      chk("jr_in4", bus.Input4Drive, 17'h100);
      tick();
      // interrupt entry and return
      clr(); jmp_tgt = 17'h5; bus.Jump = 1; #1; tick();
      clr(); bus.IrqReq = 1; #1;
      chk("irq_sel", 17'(bus.Selection), 17'd4);
      tick();
      chk("irq_pc", bus.PC, 17'd22);
      chk("irq_epc", bus.EPC, 17'h6);
      chk("irq_ack", 17'(bus.IrqAck), 17'd1);
      chk("irq_inh", 17'(bus.InHandler), 17'd1);
      clr(); #1; tick();
      chk("ack_drop", 17'(bus.IrqAck), 17'd0);
      bus.Eret = 1; #1;
      chk("eret_sel", 17'(bus.Selection), 17'd3);
      chk("eret_in4", bus.Input4Drive, 17'h6);
      tick();
      chk("eret_pc", bus.PC, 17'h6);
      chk("eret_run", 17'(bus.InHandler), 17'd0);
      // trap beats a simultaneous interrupt; interrupt follows the return
      clr(); jmp_tgt = 17'h8; bus.Jump = 1; #1; tick();
      clr(); bus.Trap = 1; bus.IrqReq = 1; #1;
      chk("trap_sel", 17'(bus.Selection), 17'd5);
      tick();
      chk("trap_pc", bus.PC, 17'd12);
      chk("trap_epc", bus.EPC, 17'h8);
      chk("trap_noack", 17'(bus.IrqAck), 17'd0);
      bus.Trap = 0; bus.Eret = 1; #1; tick();
      chk("trap_ret", bus.PC, 17'h8);
      bus.Eret = 0; #1;
      chk("late_irq_sel", 17'(bus.Selection), 17'd4);
      tick();
      chk("late_irq_pc", bus.PC, 17'd22);
      chk("late_irq_epc", bus.EPC, 17'h9);
      // double fault halts until reset
      clr(); bus.Trap = 1; #1; tick();
      chk("dfault_halt", 17'(bus.Halted), 17'd1);
      for (int i = 0; i < 10; i++) begin
         {bus.Stall, bus.BranchTaken, bus.Jump, bus.JumpReg, bus.Eret, bus.Trap, bus.IrqReq} = 7'($urandom);
         bus.RegTarget = 17'($urandom); jmp_tgt = 17'($urandom); br_tgt = 17'($urandom);
         #1;
         chk("halt_sel", 17'(bus.Selection), 17'd0);
         tick();
         chk("halt_pc", bus.PC, 17'd22);
      end
      clr(); rst = 1; #1; tick(); rst = 0;
      chk("halt_rst_pc", bus.PC, 17'd0);
      chk("halt_rst", 17'(bus.Halted), 17'd0);
      // wrap-around and stalled interrupt
      jmp_tgt = 17'h1FFFF; bus.Jump = 1; #1; tick();
      clr(); #1;
      chk("wrap_seq", bus.SeqPC, 17'd0);
      tick();
      chk("wrap_pc", bus.PC, 17'd0);
      bus.Stall = 1; bus.IrqReq = 1;
      for (int i = 0; i < 3; i++) begin
         #1; tick();
         chk("stall_pc", bus.PC, 17'd0);
         chk("stall_ack", 17'(bus.IrqAck), 17'd0);
      end
      bus.Stall = 0; #1;
      chk("unstall_sel", 17'(bus.Selection), 17'd4);
      tick();
      chk("unstall_pc", bus.PC, 17'd22);
      chk("unstall_ack", 17'(bus.IrqAck), 17'd1);
      clr(); bus.Stall = 1; #1; tick();
      chk("stall_ack_drop", 17'(bus.IrqAck), 17'd0);
      clr(); bus.Eret = 1; #1; tick();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         clr();
         rst             = $urandom_range(0, 49) == 0;
         bus.Stall       = $urandom_range(0, 5) == 0;
         bus.Trap        = $urandom_range(0, 15) == 0;
         bus.IrqReq      = $urandom_range(0, 2) == 0;
         bus.Eret        = $urandom_range(0, 3) == 0;
         bus.JumpReg     = $urandom_range(0, 3) == 0;
         bus.Jump        = $urandom_range(0, 3) == 0;
         bus.BranchTaken = $urandom_range(0, 3) == 0;
         bus.RegTarget   = 17'($urandom);
         jmp_tgt         = 17'($urandom);
         br_tgt          = 17'($urandom);
         #1; tick();
      end
      rst = 0; clr(); #1; tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
